dsp_addsub_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the processor datapath, generalising the fixed
//  32-bit DSP adder. The operand width is split into SLICE-bit slices, one slice per pipeline

---
 rtl/dsp_addsub_pipe_if.sv | 48 ++++
 rtl/dsp_addsub_pipe.sv | 143 ++++++++++++++
 tb/tb_dsp_addsub_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dsp_addsub_pipe_if.sv
// Operand/result handshake bundle for dsp_addsub_pipe.
// The master side offers operands and consumes results; the slave side is the adder.
interface dsp_addsub_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output sub,
        output sat,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  carry_out,
        input  overflow,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sub,
        input  sat,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output carry_out,
        output overflow,
        output zero
    );
endinterface

// File: rtl/dsp_addsub_pipe.sv
// Pipelined add/subtract unit: one SLICE-bit slice resolved per stage with a registered
// carry, optional signed saturation, and a stall-all valid/ready handshake.
module dsp_addsub_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 16
) (
    input logic              clk,
    input logic              rst_n,
    dsp_addsub_pipe_if.slave bus
);

    // Fallback keeps the arrays legal while the elaboration error below fires.
    localparam int unsigned NSTG = ((WIDTH >= SLICE) && ((WIDTH % SLICE) == 0)) ?
                                   (WIDTH / SLICE) : 1;

    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_param_err
        $error("dsp_addsub_pipe: WIDTH must be a non-zero multiple of SLICE");
    end

    // Rank k holds a beat whose slices below k are already summed into sum_q[k].
    logic [NSTG-1:0]  vld_q, vld_d;
    logic [NSTG-1:0]  cy_q, cy_d;
    logic [NSTG-1:0]  sat_q, sat_d;
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] bx_q  [NSTG];
    logic [WIDTH-1:0] bx_d  [NSTG];
    logic [WIDTH-1:0] sum_q [NSTG];
    logic [WIDTH-1:0] sum_d [NSTG];
    logic [SLICE:0]   sl    [NSTG];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             adv;
    logic [WIDTH-1:0] fin_sum;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cy;
    logic             fin_ovf;

    assign adv = !out_valid_q || bus.out_ready;

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            sl[k] = {1'b0, a_q[k][k*SLICE +: SLICE]} + {1'b0, bx_q[k][k*SLICE +: SLICE]} +
                    {{SLICE{1'b0}}, cy_q[k]};
        end
    end

    // Last rank: merge the top slice, then derive flags from the unsaturated sum.
    always_comb begin
        fin_sum = sum_q[NSTG-1];
        fin_sum[(NSTG-1)*SLICE +: SLICE] = sl[NSTG-1][SLICE-1:0];
        fin_cy  = sl[NSTG-1][SLICE];
        fin_ovf = (a_q[NSTG-1][WIDTH-1] == bx_q[NSTG-1][WIDTH-1]) &&
                  (fin_sum[WIDTH-1] != a_q[NSTG-1][WIDTH-1]);
        fin_res = fin_sum;
        if (sat_q[NSTG-1] && fin_ovf) begin
            fin_res = a_q[NSTG-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                             {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        vld_d       = vld_q;
        cy_d        = cy_q;
        sat_d       = sat_q;
        a_d         = a_q;
        bx_d        = bx_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        if (adv) begin
            vld_d[0] = bus.in_valid;
            a_d[0]   = bus.a;
            bx_d[0]  = bus.sub ? ~bus.b : bus.b;
            sum_d[0] = '0;
            cy_d[0]  = bus.sub;
            sat_d[0] = bus.sat;

            for (int k = 1; k < NSTG; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1];
                bx_d[k]  = bx_q[k-1];
                sum_d[k] = sum_q[k-1];
                sum_d[k][(k-1)*SLICE +: SLICE] = sl[k-1][SLICE-1:0];
                cy_d[k]  = sl[k-1][SLICE];
                sat_d[k] = sat_q[k-1];
            end

            out_valid_d = vld_q[NSTG-1];
            result_d    = fin_res;
            carry_out_d = fin_cy;
            overflow_d  = fin_ovf;
            zero_d      = (fin_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            cy_q        <= '0;
            sat_q       <= '0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            cy_q        <= cy_d;
            sat_q       <= sat_d;
            a_q         <= a_d;
            bx_q        <= bx_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Directed bench for dsp_addsub_pipe: 32-bit instance for arithmetic, stall and reset cases,
// 64-bit instance for the four-stage carry chain.
module tb_dsp_addsub_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dsp_addsub_pipe_if #(.WIDTH(32)) b32 ();
    dsp_addsub_pipe_if #(.WIDTH(64)) b64 ();

    dsp_addsub_pipe #(.WIDTH(32), .SLICE(16)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    dsp_addsub_pipe #(.WIDTH(64), .SLICE(16)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        b32.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one beat with out_ready held high; lat counts edges from accept to out_valid.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic t, input logic [31:0] er,
                         input logic ec, input logic eo, input logic ez);
        int lat;
        b32.out_ready = 1'b1;
        b32.in_valid  = 1'b1;
        b32.a         = a;
        b32.b         = b;
        b32.sub       = s;
        b32.sat       = t;
        #1;
        check({tag, "_in_ready"}, 64'(b32.in_ready), 64'd1);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        lat = 0;
        while (!b32.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"},   64'(lat),           64'd2);
        check({tag, "_res"},   64'(b32.result),    64'(er));
        check({tag, "_carry"}, 64'(b32.carry_out), 64'(ec));
        check({tag, "_ovf"},   64'(b32.overflow),  64'(eo));
        check({tag, "_zero"},  64'(b32.zero),      64'(ez));
    endtask

    logic [31:0] va [4] = '{32'h0000_0001, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] vb [4] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0078, 32'h0000_0002};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ve [4] = '{32'h0000_0003, 32'h0001_0000, 32'h1234_5600, 32'h0000_0001};

    initial begin
        logic [31:0] got_q[$];
        logic [31:0] held;
        logic        acc;
        int          sent;
        int          seen;
        int          lat;

        held = '0;
        rst_n = 1'b0;
        b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.sub = 1'b0; b32.sat = 1'b0;
        b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.a = '0; b64.b = '0; b64.sub = 1'b0; b64.sat = 1'b0;
        b64.out_ready = 1'b1;

        #22;
        check("rst_out_valid32", 64'(b32.out_valid), 64'd0);
        check("rst_out_valid64", 64'(b64.out_valid), 64'd0);
        check("rst_result32",    64'(b32.result),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);

        run32("add_ffff", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 0, 0, 0);
        run32("sub_5_3",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0002, 1, 0, 0);
        run32("sub_0_1",  32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 0, 0);
        run32("sub_5_5",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 1);
        run32("ovf_wrap", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0);
        run32("ovf_sat",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 0, 1, 0);
        run32("neg_sat",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1, 1, 0);

        // Stream four beats; out_ready drops for cycles 4..6 while beat 1 sits at the output.
        idle(2);
        sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            b32.out_ready = !(cyc >= 4 && cyc < 7);
            b32.in_valid  = (sent < 4);
            if (sent < 4) begin
                b32.a   = va[sent];
                b32.b   = vb[sent];
                b32.sub = vs[sent];
                b32.sat = 1'b0;
            end
            @(negedge clk);
            acc = b32.in_valid && b32.in_ready;
            if (!b32.out_ready) begin
                check("stall_in_ready", 64'(b32.in_ready),  64'd0);
                check("stall_valid",    64'(b32.out_valid), 64'd1);
                if (cyc == 4) held = b32.result;
                else check("stall_hold", 64'(b32.result), 64'(held));
            end
            if (b32.out_valid && b32.out_ready) got_q.push_back(b32.result);
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        check("stream_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_res%0d", i),
                  64'((i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF), 64'(ve[i]));
        end

        // Two beats in flight, then an asynchronous reset pulse between edges.
        idle(2);
        b32.in_valid = 1'b1; b32.a = 32'd1; b32.b = 32'd1; b32.sub = 1'b0; b32.sat = 1'b0;
        @(posedge clk);
        #1;
        b32.a = 32'd2;
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_valid", 64'(b32.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(b32.out_valid), 64'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (b32.out_valid) seen++;
        end
        check("rst_no_stale", 64'(seen), 64'd0);
        run32("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 0, 0, 0);
        idle(2);

        // 64-bit: carry ripples through all four slices.
        b64.a = 64'hFFFF_FFFF_FFFF_FFFF; b64.b = 64'h1; b64.sub = 1'b0; b64.sat = 1'b0;
        b64.in_valid = 1'b1;
        #1;
        check("w64_in_ready", 64'(b64.in_ready), 64'd1);
        @(posedge clk);
        #1;
        b64.in_valid = 1'b0;
        lat = 0;
        while (!b64.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w64_lat",   64'(lat),           64'd4);
        check("w64_res",   b64.result,         64'h0);
        check("w64_carry", 64'(b64.carry_out), 64'd1);
        check("w64_zero",  64'(b64.zero),      64'd1);
        check("w64_ovf",   64'(b64.overflow),  64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
